wb_cmd_master: RTL

//  Parametrised Wishbone classic-cycle master engine that drives the UART register bus from a queued command stream.

---
 rtl/wb_cmd_master_if.sv | 42 ++++
 rtl/wb_cmd_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master_if.sv
// Command/response/Wishbone bundle for wb_cmd_master.
// Ports: cmd_* (command valid/ready), rsp_* (response valid/ready), wb_* (classic Wishbone master side).
// master modport = engine view; slave modport = host/test + Wishbone-slave view.
interface wb_cmd_master_if #(
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int SEL_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_data;
  logic [SEL_W-1:0] cmd_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_data;
  logic             rsp_we;
  logic             rsp_err;

  logic [AW-1:0]    wb_addr_o;
  logic [DW-1:0]    wb_dat_o;
  logic [DW-1:0]    wb_dat_i;
  logic [SEL_W-1:0] wb_sel_o;
  logic             wb_we_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel, rsp_ready, wb_dat_i, wb_ack_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_we, rsp_err,
           wb_addr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel, rsp_ready, wb_dat_i, wb_ack_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_we, rsp_err,
           wb_addr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle master: queued commands (DEPTH-entry FIFO) executed one bus cycle at a time.
// Latency: push to cyc 2 clocks; ack to rsp_valid same edge; 3 clocks/command with immediate ack and rsp_ready.
// Backpressure: cmd_ready low when FIFO full; no new bus cycle while a response waits for rsp_ready.
// Ports: wb_clk_i/wb_rst_i (async active-high), bus (wb_cmd_master_if.master), busy_o, level_o.
// Optional macro WB_CMD_TIMEOUT_EN: abort a bus cycle with rsp_err=1 after TIMEOUT clocks without ack.
module wb_cmd_master #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int SEL_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_cmd_master_if.master        bus,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("wb_cmd_master: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  typedef struct packed {
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    data;
  } cmd_t;

  state_e           state_q, state_d;
  cmd_t             fifo_mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;
  cmd_t             cmd_in, head;

  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic [DW-1:0]    wb_dat_q, wb_dat_d;
  logic [SEL_W-1:0] wb_sel_q, wb_sel_d;
  logic             wb_we_q, wb_we_d;
  logic             cyc_q, cyc_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_we_q, rsp_we_d;

`ifdef WB_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_ONE = TW'(1);
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  assign cmd_in = '{we: bus.cmd_we, sel: bus.cmd_sel, addr: bus.cmd_addr, data: bus.cmd_data};
  assign head   = fifo_mem[rd_ptr_q];

  assign bus.cmd_ready = (level_q != LVL_FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;

  // FIFO storage carries no reset: entries are only read once the level says they were written.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= cmd_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_dat_d    = wb_dat_q;
    wb_sel_d    = wb_sel_q;
    wb_we_d     = wb_we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_we_d    = rsp_we_q;
`ifdef WB_CMD_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop       = 1'b1;
          wb_addr_d = head.addr;
          wb_dat_d  = head.data;
          wb_sel_d  = head.sel;
          wb_we_d   = head.we;
          cyc_d     = 1'b1;
          state_d   = S_BUS;
`ifdef WB_CMD_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_BUS: begin
        // Ack is checked first so an ack on the timeout edge still completes normally.
        if (bus.wb_ack_i) begin
          cyc_d       = 1'b0;
          wb_we_d     = 1'b0;
          wb_sel_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = wb_we_q ? '0 : bus.wb_dat_i;
          rsp_we_d    = wb_we_q;
          state_d     = S_RESP;
`ifdef WB_CMD_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          cyc_d       = 1'b0;
          wb_we_d     = 1'b0;
          wb_sel_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_we_d    = wb_we_q;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d       = cnt_q + CNT_ONE;
`endif
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wb_addr_q   <= '0;
      wb_dat_q    <= '0;
      wb_sel_q    <= '0;
      wb_we_q     <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_we_q    <= 1'b0;
`ifdef WB_CMD_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wb_addr_q   <= wb_addr_d;
      wb_dat_q    <= wb_dat_d;
      wb_sel_q    <= wb_sel_d;
      wb_we_q     <= wb_we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_we_q    <= rsp_we_d;
`ifdef WB_CMD_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.wb_addr_o = wb_addr_q;
  assign bus.wb_dat_o  = wb_dat_q;
  assign bus.wb_sel_o  = wb_sel_q;
  assign bus.wb_we_o   = wb_we_q;
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_we    = rsp_we_q;
`ifdef WB_CMD_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

  assign busy_o  = (state_q != S_IDLE) || (level_q != '0);
  assign level_o = level_q;

endmodule
